// File: rtl/tim_dual_if.sv
// Request/response bundle for the dual-port tightly-integrated memory:
// a read-only instruction port and a read/write data port.
interface tim_dual_if;
  logic        i_valid;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_ready;

  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb,
    input  i_rdata, i_ready, d_rdata, d_ready
  );

  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb,
    output i_rdata, i_ready, d_rdata, d_ready
  );
endinterface

// File: rtl/tim_dual.sv
// Dual-port TIM built from word-interleaved single-port banks; same-bank
// collisions are arbitrated by a toggling priority with a one-entry pending slot per port.
module tim_dual #(
  parameter int unsigned tim_depth = 1024,
  parameter int unsigned tim_width = 4
) (
  input logic       clock,
  input logic       reset,
  tim_dual_if.slave bus
);
  localparam int unsigned BW = $clog2(tim_width);
  localparam int unsigned RW = $clog2(tim_depth);
  localparam int unsigned AH = BW + RW + 1;

  typedef enum logic {PRIO_D = 1'b0, PRIO_I = 1'b1} prio_t;
  typedef logic [BW-1:0] bank_t;
  typedef logic [RW-1:0] row_t;

  prio_t       prio;
  logic        ip_v;
  bank_t       ip_bank;
  row_t        ip_row;
  logic        dp_v;
  bank_t       dp_bank;
  row_t        dp_row;
  logic [31:0] dp_wdata;
  logic [3:0]  dp_wstrb;

  logic        ci_v, cd_v;
  bank_t       ci_bank, cd_bank;
  row_t        ci_row, cd_row;
  logic [31:0] cd_wdata;
  logic [3:0]  cd_wstrb;
  logic        conflict, gi, gd;

  logic        i_rdy, d_rdy;
  bank_t       i_sel, d_sel;

  logic        bank_en  [tim_width];
  row_t        bank_row [tim_width];
  logic [3:0]  bank_we  [tim_width];
  logic [31:0] bank_q   [tim_width];
  logic [31:0] mem      [tim_width][tim_depth];

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.i_addr[31:AH+1], bus.i_addr[1:0],
                              bus.d_addr[31:AH+1], bus.d_addr[1:0]};

  // A held pending request masks the port's new strobe entirely.
  always_comb begin
    ci_v     = ip_v | bus.i_valid;
    ci_bank  = ip_v ? ip_bank : bus.i_addr[BW+1:2];
    ci_row   = ip_v ? ip_row  : bus.i_addr[AH:BW+2];
    cd_v     = dp_v | bus.d_valid;
    cd_bank  = dp_v ? dp_bank  : bus.d_addr[BW+1:2];
    cd_row   = dp_v ? dp_row   : bus.d_addr[AH:BW+2];
    cd_wdata = dp_v ? dp_wdata : bus.d_wdata;
    cd_wstrb = dp_v ? dp_wstrb : bus.d_wstrb;
    conflict = ci_v & cd_v & (ci_bank == cd_bank);
    gi       = ci_v & reset & (~conflict | (prio == PRIO_I));
    gd       = cd_v & reset & (~conflict | (prio == PRIO_D));
  end

  always_comb begin
    for (int unsigned b = 0; b < tim_width; b++) begin
      bank_en[b]  = 1'b0;
      bank_row[b] = '0;
      bank_we[b]  = '0;
      if (gi && ci_bank == bank_t'(b)) begin
        bank_en[b]  = 1'b1;
        bank_row[b] = ci_row;
      end
      if (gd && cd_bank == bank_t'(b)) begin
        bank_en[b]  = 1'b1;
        bank_row[b] = cd_row;
        bank_we[b]  = cd_wstrb;
      end
    end
  end

  // Read-first: the registered word is the value before this cycle's byte writes.
  always_ff @(posedge clock) begin
    for (int unsigned b = 0; b < tim_width; b++) begin
      if (bank_en[b]) begin
        bank_q[b] <= mem[b][bank_row[b]];
        for (int unsigned k = 0; k < 4; k++) begin
          if (bank_we[b][k]) mem[b][bank_row[b]][8*k +: 8] <= cd_wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prio     <= PRIO_D;
      ip_v     <= 1'b0;
      ip_bank  <= '0;
      ip_row   <= '0;
      dp_v     <= 1'b0;
      dp_bank  <= '0;
      dp_row   <= '0;
      dp_wdata <= '0;
      dp_wstrb <= '0;
      i_rdy    <= 1'b0;
      d_rdy    <= 1'b0;
      i_sel    <= '0;
      d_sel    <= '0;
    end else begin
      i_rdy    <= gi;
      d_rdy    <= gd;
      i_sel    <= ci_bank;
      d_sel    <= cd_bank;
      ip_v     <= ci_v & ~gi;
      ip_bank  <= ci_bank;
      ip_row   <= ci_row;
      dp_v     <= cd_v & ~gd;
      dp_bank  <= cd_bank;
      dp_row   <= cd_row;
      dp_wdata <= cd_wdata;
      dp_wstrb <= cd_wstrb;
      if (conflict) prio <= (prio == PRIO_D) ? PRIO_I : PRIO_D;
    end
  end

  assign bus.i_ready = i_rdy;
  assign bus.d_ready = d_rdy;
  assign bus.i_rdata = i_rdy ? bank_q[i_sel] : '0;
  assign bus.d_rdata = d_rdy ? bank_q[d_sel] : '0;
endmodule

// File: tb/tb_tim_dual.sv
// Self-checking bench for tim_dual: flat-memory reference model with
// per-port pending slots, directed literal checks and randomized traffic.
module tb_tim_dual;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned WORDS = DEPTH * WIDTH;

  logic clock;
  logic reset;
  tim_dual_if bus();

  tim_dual #(.tim_depth(DEPTH), .tim_width(WIDTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: one flat word array, addresses folded to word index.
  typedef struct {
    bit          v;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  s;
  } req_t;

  logic [31:0] mmem [WORDS];
  req_t        mp_i, mp_d;
  bit          m_prio_i;
  logic        e_i_ready, e_d_ready;
  logic [31:0] e_i_rdata, e_d_rdata;

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % WORDS;
  endfunction

  function automatic int unsigned wbank(input logic [31:0] a);
    return (a >> 2) % WIDTH;
  endfunction

  initial begin
    for (int i = 0; i < WORDS; i++) mmem[i] = '0;
    mp_i = '{v: 1'b0, a: '0, wd: '0, s: '0};
    mp_d = '{v: 1'b0, a: '0, wd: '0, s: '0};
    m_prio_i = 1'b0;
    e_i_ready = 1'b0; e_d_ready = 1'b0; e_i_rdata = '0; e_d_rdata = '0;
  end

  always @(posedge clock) begin
    req_t ci, cd;
    bit gi, gd;
    if (!reset) begin
      mp_i.v = 1'b0; mp_d.v = 1'b0; m_prio_i = 1'b0;
      e_i_ready = 1'b0; e_d_ready = 1'b0; e_i_rdata = '0; e_d_rdata = '0;
    end else begin
      ci = mp_i.v ? mp_i : '{v: bus.i_valid, a: bus.i_addr, wd: '0, s: '0};
      cd = mp_d.v ? mp_d : '{v: bus.d_valid, a: bus.d_addr, wd: bus.d_wdata, s: bus.d_wstrb};
      gi = ci.v; gd = cd.v;
      if (ci.v && cd.v && wbank(ci.a) == wbank(cd.a)) begin
        if (m_prio_i) gd = 1'b0; else gi = 1'b0;
        m_prio_i = !m_prio_i;
      end
      mp_i = ci; mp_i.v = ci.v && !gi;
      mp_d = cd; mp_d.v = cd.v && !gd;
      e_i_ready = gi;
      e_i_rdata = gi ? mmem[widx(ci.a)] : '0;
      e_d_ready = gd;
      e_d_rdata = gd ? mmem[widx(cd.a)] : '0;
      if (gd)
        for (int k = 0; k < 4; k++)
          if (cd.s[k]) mmem[widx(cd.a)][8*k +: 8] = cd.wd[8*k +: 8];
    end
  end

  always @(negedge clock) begin
    check("i_ready", {31'b0, bus.i_ready}, {31'b0, e_i_ready});
    check("d_ready", {31'b0, bus.d_ready}, {31'b0, e_d_ready});
    check("i_rdata", bus.i_rdata, e_i_rdata);
    check("d_rdata", bus.d_rdata, e_d_rdata);
  end

  // Each call captures the outputs produced by the previous call's inputs.
  logic        l_i_ready, l_d_ready;
  logic [31:0] l_i_rdata, l_d_rdata;

  task automatic cyc(input logic iv, input logic [31:0] ia, input logic dv,
                     input logic [31:0] da, input logic [31:0] dw,
                     input logic [3:0] ds, input logic rst);
    @(negedge clock);
    l_i_ready = bus.i_ready; l_d_ready = bus.d_ready;
    l_i_rdata = bus.i_rdata; l_d_rdata = bus.d_rdata;
    #1;
    bus.i_valid = iv; bus.i_addr = ia;
    bus.d_valid = dv; bus.d_addr = da; bus.d_wdata = dw; bus.d_wstrb = ds;
    reset = rst;
  endtask

  task automatic idle(input logic rst);
    cyc(1'b0, '0, 1'b0, '0, '0, 4'h0, rst);
  endtask

  task automatic conflict_req();
    cyc(1'b1, 32'h0, 1'b1, 32'h10, '0, 4'h0, 1'b1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = ($urandom & 32'hFFFF_C000) | ($urandom_range(0, 7) << 4)
        | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
    return a;
  endfunction

  initial begin
    reset = 1'b0;
    bus.i_valid = 1'b0; bus.i_addr = '0;
    bus.d_valid = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
    repeat (3) idle(1'b0);
    idle(1'b1);
    for (int k = 0; k < 32; k++)
      cyc(1'b0, '0, 1'b1, 32'(k * 4), 32'hA500_0000 | 32'(k), 4'hF, 1'b1);
    idle(1'b1);

    // Full write then read-back, including old-word return on the write.
    cyc(1'b0, '0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1);
    cyc(1'b0, '0, 1'b1, 32'h10, '0, 4'h0, 1'b1);
    check("wr_ready", {31'b0, l_d_ready}, 32'd1);
    check("wr_old", l_d_rdata, 32'hA500_0004);
    idle(1'b1);
    check("rd_ready", {31'b0, l_d_ready}, 32'd1);
    check("rd_full", l_d_rdata, 32'hDEAD_BEEF);

    cyc(1'b0, '0, 1'b1, 32'h4010, '0, 4'h0, 1'b1);
    idle(1'b1);
    check("alias", l_d_rdata, 32'hDEAD_BEEF);

    cyc(1'b0, '0, 1'b1, 32'h10, 32'h0000_AA00, 4'h2, 1'b1);
    cyc(1'b0, '0, 1'b1, 32'h10, '0, 4'h0, 1'b1);
    idle(1'b1);
    check("strb_rd", l_d_rdata, 32'hDEAD_AAEF);

    cyc(1'b1, 32'h0, 1'b1, 32'h4, '0, 4'h0, 1'b1);
    idle(1'b1);
    check("par_i_ready", {31'b0, l_i_ready}, 32'd1);
    check("par_d_ready", {31'b0, l_d_ready}, 32'd1);
    check("par_i_rdata", l_i_rdata, 32'hA500_0000);
    check("par_d_rdata", l_d_rdata, 32'hA500_0001);

    repeat (2) idle(1'b0);
    idle(1'b1);
    conflict_req();
    idle(1'b1);
    check("c1_d_first", {31'b0, l_d_ready}, 32'd1);
    check("c1_i_wait", {31'b0, l_i_ready}, 32'd0);
    check("c1_d_rdata", l_d_rdata, 32'hDEAD_AAEF);
    idle(1'b1);
    check("c1_i_late", {31'b0, l_i_ready}, 32'd1);
    check("c1_i_rdata", l_i_rdata, 32'hA500_0000);
    conflict_req();
    idle(1'b1);
    check("c2_i_first", {31'b0, l_i_ready}, 32'd1);
    check("c2_d_wait", {31'b0, l_d_ready}, 32'd0);
    idle(1'b1);
    check("c2_d_late", {31'b0, l_d_ready}, 32'd1);

    // Reset while the instruction request sits in its pending slot.
    conflict_req();
    idle(1'b0);
    check("c3_d_first", {31'b0, l_d_ready}, 32'd1);
    idle(1'b0);
    idle(1'b1);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      check("dropped_i", {31'b0, l_i_ready}, 32'd0);
    end
    conflict_req();
    idle(1'b1);
    check("c4_d_first", {31'b0, l_d_ready}, 32'd1);
    check("c4_i_wait", {31'b0, l_i_ready}, 32'd0);
    idle(1'b1);
    check("c4_i_late", {31'b0, l_i_ready}, 32'd1);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        idle(1'b0);
      end else begin
        cyc($urandom_range(0, 1) == 1, rand_addr(), $urandom_range(0, 1) == 1,
            rand_addr(), $urandom, ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom),
            1'b1);
      end
    end
    repeat (4) idle(1'b1);
    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tim_dual.md
TIM_DUAL -- requirements
Module: tim_dual

Interface
REQ-001 Parameter tim_depth, default 1024, SHALL set the words per bank (power of two, >=2).
REQ-002 Parameter tim_width, default 4, SHALL set the number of 32-bit word-interleaved banks (power of two, >=2).
REQ-003 Port clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  SHALL be an asynchronous, active-low reset.
REQ-005 Port i_valid  in  1  SHALL be the instruction-port request strobe (read-only port).
REQ-006 Port i_addr  in  32  SHALL be the instruction-port byte address.
REQ-007 Port i_rdata  out  32  SHALL be the instruction-port read data.
REQ-008 Port i_ready  out  1  SHALL be the instruction-port completion pulse.
REQ-009 Port d_valid  in  1  SHALL be the data-port request strobe.
REQ-010 Port d_addr  in  32  SHALL be the data-port byte address.
REQ-011 Port d_wdata  in  32  SHALL be the data-port write data.
REQ-012 Port d_wstrb  in  4  SHALL be the data-port byte write strobes; 0 means read.
REQ-013 Port d_rdata  out  32  SHALL be the data-port read data.
REQ-014 Port d_ready  out  1  SHALL be the data-port completion pulse.

Function
REQ-015 Bank index SHALL be addr[log2(tim_width)+1:2].
REQ-016 Row SHALL be the next log2(tim_depth) address bits; higher bits and addr[1:0] SHALL be ignored, so addresses alias modulo tim_depth*tim_width*4 bytes.
REQ-017 A port SHALL accept a request on valid=1 only when it holds no pending request; valid while pending SHALL be ignored and never acknowledged.
REQ-018 Banks SHALL be single-port, synchronous, one access per cycle, read-first (read data is the word before that cycle's write).
REQ-019 Requests from the two ports to different banks in the same cycle SHALL both access their banks that cycle, ready in the next cycle.
REQ-020 Latency without conflict SHALL be exactly 1 cycle: valid in cycle N, ready=1 with rdata in cycle N+1.
REQ-021 Conflict (both ports need the same bank in one cycle, whether new or pending) SHALL grant the port named by priority bit prio; the loser SHALL be captured in its one-entry pending register.
REQ-022 prio SHALL toggle after every conflict, so a loser is granted in the next cycle (maximum added wait 1 cycle).
REQ-023 A pending request SHALL be re-arbitrated each cycle exactly as a new request.
REQ-024 Writes SHALL update only bytes with d_wstrb[k]=1; d_ready SHALL pulse for writes as for reads, with d_rdata the old word.
REQ-025 ready SHALL be high exactly one cycle per accepted request; rdata SHALL be 0 whenever its ready is 0.
REQ-026 Same row, same cycle, instruction read vs data write: if the data port wins, the instruction port sees new data next cycle; if the instruction port wins, it sees old data.

Reset
REQ-027 While reset=0: i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, pending registers empty, prio=data port.
REQ-028 Requests in flight or pending at reset SHALL be dropped with no ready pulse after release; memory contents SHALL be preserved.
REQ-029 Memory SHALL power up at all zeros in simulation; no reset clear of memory.

Verification (tim_width=4, tim_depth=1024)
REQ-030 Write d_addr=0x10, d_wdata=0xDEADBEEF, d_wstrb=0xF, then read 0x10 -> each d_ready one cycle later; read returns 0xDEADBEEF.
REQ-031 Write 0x10, d_wstrb=0x2, d_wdata=0x0000AA00, then read 0x10 -> 0xDEADAAEF.
REQ-032 Same cycle i_addr=0x0 (bank 0), d_addr=0x4 (bank 1) -> i_ready and d_ready both in cycle N+1.
REQ-033 From reset, same cycle i_addr=0x0, d_addr=0x10 (both bank 0) -> d_ready N+1, i_ready N+2; repeated conflict -> i_ready first.
REQ-034 Read 0x4010 after REQ-030 write -> 0xDEADBEEF (alias of 0x10).
REQ-035 Assert reset while instruction request pending after a conflict -> no i_ready after release; next conflict grants the data port first.
